// File: rtl/opsg_i2s_tx.sv
// opsg_i2s_tx: Philips-I2S transmitter for the OPSG stereo mix, with DC offset removal and per-frame sample capture.
module opsg_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH = 16,
  parameter int BCLK_DIV = 4,
  parameter int DC_OFFSET = 8192
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    en,
  input  logic [SAMPLE_WIDTH-1:0] audio_left,
  input  logic [SAMPLE_WIDTH-1:0] audio_right,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_sdata,
  output logic                    sample_strobe
);
  localparam int FW = 2 * SLOT_WIDTH;
  localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(FW - 1);
  localparam logic [SAMPLE_WIDTH-1:0] OFS = SAMPLE_WIDTH'(DC_OFFSET);
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt, cnt_nx;
  logic [FW-1:0] sh, sh_nx;
  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
  logic wrap, fall;
  // The load in period 1 (one period after capture) provides the I2S one-bit delay behind LRCLK.
  always_comb begin
    wrap = en && div == DIV_MAX;
    fall = wrap && i2s_bclk;
    cnt_nx = bit_cnt == CNT_MAX ? '0 : bit_cnt + BW'(1);
    sh_nx = cnt_nx == BW'(1) ? (FW'(hold_l) << (FW - SAMPLE_WIDTH)) | (FW'(hold_r) << (SLOT_WIDTH - SAMPLE_WIDTH)) : sh << 1;
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      div <= '0;
      bit_cnt <= CNT_MAX;
      sh <= '0;
      hold_l <= '0;
      hold_r <= '0;
      i2s_bclk <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      sample_strobe <= 1'b0;
    end else if (en) begin
      div <= wrap ? '0 : div + DW'(1);
      if (wrap) i2s_bclk <= ~i2s_bclk;
      sample_strobe <= fall && cnt_nx == '0;
      if (fall) begin
        bit_cnt <= cnt_nx;
        i2s_lrclk <= cnt_nx >= BW'(SLOT_WIDTH);
        sh <= sh_nx;
        i2s_sdata <= sh_nx[FW-1];
        if (cnt_nx == '0) begin
          hold_l <= audio_left - OFS;
          hold_r <= audio_right - OFS;
        end
      end
    end else
      sample_strobe <= 1'b0;
endmodule

// File: tb/tb_opsg_i2s_tx.sv
// tb_opsg_i2s_tx: randomized scoreboard bench; an I2S receiver model decodes words and checks them against captured inputs.
module tb_opsg_i2s_tx;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic en = 1'b0;
  logic [15:0] audio_left = '0, audio_right = '0, cur_l = '0, cur_r = '0;
  logic [1:0] bclk, lrclk, sdata, strobe;
  int errors = 0, checks = 0, t = 0;
  logic last_en = 1'b0;
  logic [16:0] exp_mem [2][256];
  int wr_p [2] = '{0, 0};
  int rd_p [2] = '{0, 0};
  logic [31:0] acc [2];
  logic plr [2];
  logic pbc [2];

  opsg_i2s_tx u_a (
    .clk(clk), .n_rst(n_rst), .en(en), .audio_left(audio_left), .audio_right(audio_right),
    .i2s_bclk(bclk[0]), .i2s_lrclk(lrclk[0]), .i2s_sdata(sdata[0]), .sample_strobe(strobe[0])
  );
  opsg_i2s_tx #(.SLOT_WIDTH(20), .BCLK_DIV(2), .DC_OFFSET(0)) u_b (
    .clk(clk), .n_rst(n_rst), .en(en), .audio_left(audio_left), .audio_right(audio_right),
    .i2s_bclk(bclk[1]), .i2s_lrclk(lrclk[1]), .i2s_sdata(sdata[1]), .sample_strobe(strobe[1])
  );

  always #5 clk = ~clk;

  function automatic int sw(int k); return k == 0 ? 16 : 20; endfunction
  function automatic int dv(int k); return k == 0 ? 4 : 2; endfunction
  function automatic logic [15:0] ofs(int k); return k == 0 ? 16'd8192 : 16'd0; endfunction
  function automatic logic cap(int k, int tt);
    return tt >= 2 * dv(k) && (tt - 2 * dv(k)) % (4 * dv(k) * sw(k)) == 0;
  endfunction
  // Expected {bclk, lrclk, strobe} after tt enabled clk edges since reset release.
  function automatic logic [2:0] wave(int k, int tt, logic le);
    logic lr_e;
    lr_e = tt >= 2 * dv(k) && ((tt / (2 * dv(k)) - 1) % (2 * sw(k))) >= sw(k);
    return {1'((tt / dv(k)) % 2), lr_e, le && cap(k, tt)};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
    end
  endtask

  task automatic zeros(string name);
    for (int k = 0; k < 2; k++)
      check(name, 64'({bclk[k], lrclk[k], sdata[k], strobe[k]}), 64'(0));
  endtask

  task automatic cyc(logic e, logic [15:0] l, logic [15:0] r);
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("wave%0d", k), 64'({bclk[k], lrclk[k], strobe[k]}), 64'(wave(k, t, last_en)));
    en = e;
    last_en = e;
    audio_left = l;
    audio_right = r;
    if (e) begin
      t++;
      for (int k = 0; k < 2; k++)
        if (cap(k, t)) begin
          exp_mem[k][wr_p[k] % 256] = {1'b0, l - ofs(k)};
          exp_mem[k][(wr_p[k] + 1) % 256] = {1'b1, r - ofs(k)};
          wr_p[k] += 2;
        end
    end
  endtask

  task automatic run(int n, int p_chg, int p_stall);
    for (int i = 0; i < n; i++) begin
      if (p_chg != 0 && $urandom % p_chg == 0) begin
        cur_l = 16'($urandom);
        cur_r = 16'($urandom);
      end
      cyc(p_stall == 0 || $urandom % p_stall != 0, cur_l, cur_r);
    end
  endtask

  task automatic until_t(int m, int v);
    while (t % m != v) cyc(1'b1, cur_l, cur_r);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1 zeros("rst_now");
    repeat (3) begin
      @(negedge clk);
      zeros("rst_hold");
    end
    @(posedge clk);
    #2 n_rst = 1'b1;
    t = 0;
    last_en = 1'b0;
  endtask

  // Receiver: a bit sampled on a BCLK rise belongs to the channel LRCLK selected on the previous rise.
  always @(negedge clk) begin
    logic [16:0] ent;
    logic [31:0] mask;
    for (int k = 0; k < 2; k++) begin
      if (!n_rst) begin
        acc[k] = '0;
        plr[k] = 1'b0;
        pbc[k] = 1'b0;
        rd_p[k] = wr_p[k];
      end else begin
        if (bclk[k] && !pbc[k]) begin
          acc[k] = {acc[k][30:0], sdata[k]};
          if (lrclk[k] != plr[k]) begin
            if (rd_p[k] == wr_p[k]) begin
              checks++;
              errors++;
              $display("FAIL underflow%0d t=%0d got=word want=none", k, t);
            end else begin
              ent = exp_mem[k][rd_p[k] % 256];
              rd_p[k]++;
              mask = (32'd1 << sw(k)) - 32'd1;
              check($sformatf("word%0d", k), 64'({plr[k], acc[k] & mask}),
                    64'({ent[16], 32'(ent[15:0]) << (sw(k) - 16)}));
            end
          end
          plr[k] = lrclk[k];
        end
        pbc[k] = bclk[k];
      end
    end
  end

  initial begin
    do_reset();
    cur_l = 16'd16384;
    cur_r = 16'd0;
    run(600, 0, 0);
    cur_l = 16'hA5A5;
    cur_r = 16'h5A5A;
    run(600, 0, 0);
    cur_l = 16'h1234;
    until_t(256, 60);
    cur_l = 16'hFFFF;
    run(500, 0, 0);
    run(1200, 40, 0);
    until_t(256, 50);
    repeat (37) cyc(1'b0, 16'($urandom), 16'($urandom));
    run(600, 0, 0);
    run(1500, 30, 15);
    until_t(256, 170);
    do_reset();
    run(1200, 40, 0);
    for (int k = 0; k < 2; k++) check($sformatf("words%0d", k), 64'(rd_p[k] >= 40), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
